// File: rtl/multi_digit_bcd_counter.sv
// rtl/multi_digit_bcd_counter.sv - N-digit BCD up/down counter with runtime limit, load and carry pulses
module multi_digit_bcd_counter #(
   parameter int DIGITS    = 4,
   parameter int WRAP_MODE = 1
) (
   input  logic                  bcd_clk_i,
   input  logic                  bcd_nreset_i,
   input  logic                  up_i,
   input  logic                  down_i,
   input  logic                  load_i,
   input  logic [4*DIGITS-1:0]   load_value_i,
   input  logic [4*DIGITS-1:0]   limit_i,
   output logic [4*DIGITS-1:0]   count_o,
   output logic                  at_limit_o,
   output logic                  at_zero_o,
   output logic                  carryup_o,
   output logic                  carrydown_o
);

   localparam int W = 4 * DIGITS;

   logic [W-1:0] count_q;
   logic         carryup_q;
   logic         carrydown_q;
   logic [W-1:0] lim;
   logic [W-1:0] load_san;
   logic [W-1:0] next_count;
   logic         next_carryup;
   logic         next_carrydown;

   // Clamp every nibble above 9 down to 9 so all compares are plain BCD compares.
   function automatic logic [W-1:0] sanitize(input logic [W-1:0] v);
      logic [W-1:0] r;
      r = '0;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = (v[4*i +: 4] > 4'd9) ? 4'd9 : v[4*i +: 4];
      end
      return r;
   endfunction

   // Ripple BCD increment; callers guarantee the value is below the limit so it never overflows.
   function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
      logic [W-1:0] r;
      logic         c;
      r = v;
      c = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (c) begin
            if (v[4*i +: 4] >= 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] + 4'd1;
               c = 1'b0;
            end
         end
      end
      return r;
   endfunction

   // Ripple BCD decrement; callers guarantee the value is non-zero so it never underflows.
   function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
      logic [W-1:0] r;
      logic         b;
      r = v;
      b = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (b) begin
            if (v[4*i +: 4] == 4'd0) begin
               r[4*i +: 4] = 4'd9;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] - 4'd1;
               b = 1'b0;
            end
         end
      end
      return r;
   endfunction

   assign lim      = sanitize(limit_i);
   assign load_san = sanitize(load_value_i);

   // Next-state selection: load > up > down > hold, with wrap or saturate at the boundaries.
   always_comb begin
      next_count     = count_q;
      next_carryup   = 1'b0;
      next_carrydown = 1'b0;
      if (load_i) begin
         next_count = (load_san > lim) ? lim : load_san;
      end else if (up_i) begin
         if (count_q < lim) begin
            next_count = bcd_inc(count_q);
         end else if (WRAP_MODE != 0) begin
            next_count   = '0;
            next_carryup = 1'b1;
         end else begin
            next_count = lim;
         end
      end else if (down_i) begin
         if (count_q > lim) begin
            next_count = lim;
         end else if (count_q != '0) begin
            next_count = bcd_dec(count_q);
         end else if (WRAP_MODE != 0) begin
            next_count     = lim;
            next_carrydown = 1'b1;
         end
      end
   end

   // Count and carry registers with synchronous active-low reset.
   always_ff @(posedge bcd_clk_i) begin
      if (!bcd_nreset_i) begin
         count_q     <= '0;
         carryup_q   <= 1'b0;
         carrydown_q <= 1'b0;
      end else begin
         count_q     <= next_count;
         carryup_q   <= next_carryup;
         carrydown_q <= next_carrydown;
      end
   end

   assign count_o     = count_q;
   assign carryup_o   = carryup_q;
   assign carrydown_o = carrydown_q;
   assign at_limit_o  = (count_q == lim);
   assign at_zero_o   = (count_q == '0);

endmodule

// File: tb/tb_multi_digit_bcd_counter.sv
// tb/tb_multi_digit_bcd_counter.sv - directed checks for multi_digit_bcd_counter
module tb_multi_digit_bcd_counter;

   logic clk = 1'b0;
   logic nreset;

   logic        a_up, a_down, a_load;
   logic [7:0]  a_lv, a_lim, a_cnt;
   logic        a_atl, a_atz, a_cu, a_cd;

   logic        b_up, b_down, b_load;
   logic [15:0] b_lv, b_lim, b_cnt;
   logic        b_atl, b_atz, b_cu, b_cd;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   multi_digit_bcd_counter #(.DIGITS(2), .WRAP_MODE(1)) u_a (
      .bcd_clk_i   (clk),
      .bcd_nreset_i(nreset),
      .up_i        (a_up),
      .down_i      (a_down),
      .load_i      (a_load),
      .load_value_i(a_lv),
      .limit_i     (a_lim),
      .count_o     (a_cnt),
      .at_limit_o  (a_atl),
      .at_zero_o   (a_atz),
      .carryup_o   (a_cu),
      .carrydown_o (a_cd)
   );

   multi_digit_bcd_counter #(.DIGITS(4), .WRAP_MODE(0)) u_b (
      .bcd_clk_i   (clk),
      .bcd_nreset_i(nreset),
      .up_i        (b_up),
      .down_i      (b_down),
      .load_i      (b_load),
      .load_value_i(b_lv),
      .limit_i     (b_lim),
      .count_o     (b_cnt),
      .at_limit_o  (b_atl),
      .at_zero_o   (b_atz),
      .carryup_o   (b_cu),
      .carrydown_o (b_cd)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_a();
      a_up = 1'b0; a_down = 1'b0; a_load = 1'b0;
   endtask

   task automatic idle_b();
      b_up = 1'b0; b_down = 1'b0; b_load = 1'b0;
   endtask

   task automatic test_reset();
      nreset = 1'b0;
      idle_a(); idle_b();
      a_lv = 8'h00; a_lim = 8'h23; b_lv = 16'h0000; b_lim = 16'h9999;
      tick();
      tick();
      total++;
      if (a_cnt !== 8'h00 || a_cu !== 1'b0 || a_cd !== 1'b0) begin
         bad++;
         $display("FAIL reset_a: count=%h cu=%b cd=%b, required 00 0 0", a_cnt, a_cu, a_cd);
      end
      total++;
      if (b_cnt !== 16'h0000 || b_cu !== 1'b0 || b_cd !== 1'b0 || b_atz !== 1'b1) begin
         bad++;
         $display("FAIL reset_b: count=%h cu=%b cd=%b z=%b, required 0000 0 0 1", b_cnt, b_cu, b_cd, b_atz);
      end
      nreset = 1'b1;
   endtask

   task automatic test_up_wrap();
      int d;
      logic [7:0] exp;
      int errs;
      errs = 0;
      a_lim = 8'h23;
      a_up  = 1'b1;
      for (int i = 1; i <= 24; i++) begin
         tick();
         d   = i % 24;
         exp = 8'((d / 10) * 16 + (d % 10));
         total++;
         if (a_cnt !== exp || a_cu !== (i == 24)) begin
            bad++;
            $display("FAIL up_wrap step %0d: count=%h cu=%b, required %h %b", i, a_cnt, a_cu, exp, (i == 24));
         end
      end
      a_up = 1'b0;
      tick();
      total++;
      if (a_cnt !== 8'h00 || a_cu !== 1'b0) begin
         bad++;
         $display("FAIL up_wrap_hold: count=%h cu=%b, required 00 0", a_cnt, a_cu);
      end
   endtask

   task automatic test_down_wrap();
      nreset = 1'b0;
      tick();
      nreset = 1'b1;
      a_lim  = 8'h59;
      a_down = 1'b1;
      tick();
      total++;
      if (a_cnt !== 8'h59 || a_cd !== 1'b1 || a_atl !== 1'b1) begin
         bad++;
         $display("FAIL down_wrap: count=%h cd=%b lim=%b, required 59 1 1", a_cnt, a_cd, a_atl);
      end
      tick();
      total++;
      if (a_cnt !== 8'h58 || a_cd !== 1'b0) begin
         bad++;
         $display("FAIL down_58: count=%h cd=%b, required 58 0", a_cnt, a_cd);
      end
      for (int i = 0; i < 8; i++) tick();
      total++;
      if (a_cnt !== 8'h50) begin
         bad++;
         $display("FAIL down_50: count=%h, required 50", a_cnt);
      end
      tick();
      total++;
      if (a_cnt !== 8'h49 || a_cd !== 1'b0) begin
         bad++;
         $display("FAIL down_borrow: count=%h cd=%b, required 49 0", a_cnt, a_cd);
      end
      a_down = 1'b0;
   endtask

   task automatic test_saturate();
      b_lim  = 16'h9999;
      b_lv   = 16'h9998;
      b_load = 1'b1;
      tick();
      b_load = 1'b0;
      total++;
      if (b_cnt !== 16'h9998 || b_cu !== 1'b0 || b_cd !== 1'b0) begin
         bad++;
         $display("FAIL sat_load: count=%h cu=%b cd=%b, required 9998 0 0", b_cnt, b_cu, b_cd);
      end
      b_up = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++;
         if (b_cnt !== 16'h9999 || b_cu !== 1'b0 || b_atl !== 1'b1) begin
            bad++;
            $display("FAIL sat_up %0d: count=%h cu=%b lim=%b, required 9999 0 1", i, b_cnt, b_cu, b_atl);
         end
      end
      b_up   = 1'b0;
      b_lv   = 16'h0000;
      b_load = 1'b1;
      tick();
      b_load = 1'b0;
      b_down = 1'b1;
      tick();
      b_down = 1'b0;
      total++;
      if (b_cnt !== 16'h0000 || b_cd !== 1'b0 || b_atz !== 1'b1) begin
         bad++;
         $display("FAIL sat_down: count=%h cd=%b z=%b, required 0000 0 1", b_cnt, b_cd, b_atz);
      end
   endtask

   task automatic test_load_clamp();
      b_lim  = 16'h0023;
      b_lv   = 16'h0057;
      b_load = 1'b1;
      tick();
      total++;
      if (b_cnt !== 16'h0023 || b_atl !== 1'b1) begin
         bad++;
         $display("FAIL load_clamp: count=%h lim=%b, required 0023 1", b_cnt, b_atl);
      end
      b_lv = 16'h0000;
      tick();
      b_lv = 16'h00AF;
      tick();
      total++;
      if (b_cnt !== 16'h0023) begin
         bad++;
         $display("FAIL load_sanitise: count=%h, required 0023", b_cnt);
      end
      b_lim = 16'h0099;
      tick();
      total++;
      if (b_cnt !== 16'h0099) begin
         bad++;
         $display("FAIL load_sanitise_wide: count=%h, required 0099", b_cnt);
      end
      b_lim = 16'h0023;
      b_lv  = 16'h0005;
      tick();
      b_load = 1'b0;
      b_up   = 1'b1;
      b_down = 1'b1;
      tick();
      idle_b();
      total++;
      if (b_cnt !== 16'h0006) begin
         bad++;
         $display("FAIL up_wins: count=%h, required 0006", b_cnt);
      end
   endtask

   task automatic test_limit_lowered();
      idle_a();
      a_lim  = 8'h99;
      a_lv   = 8'h45;
      a_load = 1'b1;
      tick();
      a_load = 1'b0;
      a_lim  = 8'h23;
      tick();
      total++;
      if (a_cnt !== 8'h45 || a_atl !== 1'b0) begin
         bad++;
         $display("FAIL lowered_hold: count=%h lim=%b, required 45 0", a_cnt, a_atl);
      end
      a_down = 1'b1;
      tick();
      a_down = 1'b0;
      total++;
      if (a_cnt !== 8'h23 || a_cd !== 1'b0) begin
         bad++;
         $display("FAIL lowered_down: count=%h cd=%b, required 23 0", a_cnt, a_cd);
      end
      a_lim  = 8'h99;
      a_load = 1'b1;
      tick();
      a_load = 1'b0;
      a_lim  = 8'h23;
      a_up   = 1'b1;
      tick();
      a_up = 1'b0;
      total++;
      if (a_cnt !== 8'h00 || a_cu !== 1'b1) begin
         bad++;
         $display("FAIL lowered_up: count=%h cu=%b, required 00 1", a_cnt, a_cu);
      end
   endtask

   task automatic test_reset_priority();
      a_lim  = 8'h23;
      a_lv   = 8'h23;
      a_load = 1'b1;
      tick();
      a_load = 1'b0;
      a_up   = 1'b1;
      a_load = 1'b1;
      a_lv   = 8'h12;
      nreset = 1'b0;
      tick();
      total++;
      if (a_cnt !== 8'h00 || a_cu !== 1'b0 || a_cd !== 1'b0) begin
         bad++;
         $display("FAIL reset_prio: count=%h cu=%b cd=%b, required 00 0 0", a_cnt, a_cu, a_cd);
      end
      nreset = 1'b1;
      a_load = 1'b0;
      tick();
      total++;
      if (a_cnt !== 8'h01 || a_cu !== 1'b0) begin
         bad++;
         $display("FAIL reset_resume: count=%h cu=%b, required 01 0", a_cnt, a_cu);
      end
      idle_a();
   endtask

   task automatic test_zero_limit();
      a_lim = 8'h00;
      a_lv  = 8'h00;
      a_load = 1'b1;
      tick();
      a_load = 1'b0;
      a_up   = 1'b1;
      tick();
      tick();
      total++;
      if (a_cnt !== 8'h00 || a_cu !== 1'b1) begin
         bad++;
         $display("FAIL zero_lim_up: count=%h cu=%b, required 00 1", a_cnt, a_cu);
      end
      a_up   = 1'b0;
      a_down = 1'b1;
      tick();
      a_down = 1'b0;
      total++;
      if (a_cnt !== 8'h00 || a_cd !== 1'b1 || a_cu !== 1'b0) begin
         bad++;
         $display("FAIL zero_lim_down: count=%h cd=%b cu=%b, required 00 1 0", a_cnt, a_cd, a_cu);
      end
   endtask

   initial begin
      test_reset();
      test_up_wrap();
      test_down_wrap();
      test_saturate();
      test_load_clamp();
      test_limit_lowered();
      test_reset_priority();
      test_zero_limit();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
